// File: rtl/key_debounce.sv
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Synchronises a raw mechanical key pin and filters contact
//             bounce with a counter-qualified FSM. Produces a clean pressed
//             level plus single-cycle press / release strobes.
//  Option   : define KEY_DEBOUNCE_LONG_PRESS_EN to enable the long-press
//             strobe (long_pulse); otherwise long_pulse is tied low.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 20,
    parameter int STABLE_CYC  = 1000000,
    parameter bit ACTIVE_LOW  = 1'b1,
    parameter int LONG_CYC    = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    // Last count value of a qualification window; 0 when STABLE_CYC==1, so
    // the very first sample at the new level is accepted with no WAIT dwell.
    localparam logic [CNT_W-1:0]       STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [SYNC_STAGES-1:0] SYNC_RST    = {SYNC_STAGES{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_p;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;

    // Synchroniser chain; resets to the released pin level so no false press
    // is seen while the chain refills after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= SYNC_RST;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], key_in};
        end
    end

    // Normalised key: 1 means pressed regardless of pin polarity.
    assign w_p = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Next-state logic: a change must be seen STABLE_CYC consecutive samples
    // before it is accepted; any sample back at the old level aborts.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
                if (w_p) begin
                    if (r_cnt == STABLE_LAST) begin
                        w_state_nxt = PRESSED;
                        w_level_nxt = 1'b1;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_state_nxt = PRESS_WAIT;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!w_p) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b1;
                if (!w_p) begin
                    if (r_cnt == STABLE_LAST) begin
                        w_state_nxt   = IDLE;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RELEASE_WAIT;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (w_p) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign key_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int              LONG_W    = $clog2(LONG_CYC + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYC);

    logic [LONG_W-1:0] r_lcnt;
    logic              r_long;

    // Hold-time counter: cleared on a newly accepted press, counts while
    // PRESSED, holds through a release glitch so a bounce does not restart
    // it, and parks at LONG_CYC after firing so each press fires once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lcnt <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_press_nxt) begin
                r_lcnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_lcnt <= '0;
                    end
                    PRESSED: begin
                        if (r_lcnt == LONG_LAST) begin
                            r_long <= 1'b1;
                            r_lcnt <= LONG_SAT;
                        end else if (r_lcnt != LONG_SAT) begin
                            r_lcnt <= r_lcnt + LONG_W'(1);
                        end
                    end
                    default: begin
                        r_lcnt <= r_lcnt;
                    end
                endcase
            end
        end
    end

    assign long_pulse = r_long;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

`default_nettype wire
